// File: rtl/light_sequencer.sv
// RGB light sequencer: white / manual-step / timed auto-cycle / off, with
// direction control, brightness dimming and one registered RGB word per clock.
module light_sequencer #(
  parameter int CH_WIDTH = 8,
  parameter int DWELL    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  button,
  input  logic                  dir,
  input  logic [1:0]            dim,
  output logic [3*CH_WIDTH-1:0] light,
  output logic [2:0]            colour,
  output logic                  step
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    MODE_WHITE  = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  btn_q;
  logic                  press;
  logic [2:0]            colour_nxt;
  logic                  step_nxt;
  logic [3*CH_WIDTH-1:0] light_nxt;
  logic [CH_WIDTH-1:0]   on_level;

  // Codes 0 and 7 never come out of stepping; both re-enter the ring at its start.
  function automatic logic [2:0] next_colour(input logic [2:0] c, input logic rev);
    logic [2:0] n;
    if (!rev) n = (c == 3'd0 || c >= 3'd6) ? 3'd1 : c + 3'd1;
    else      n = (c <= 3'd1 || c == 3'd7) ? 3'd6 : c - 3'd1;
    return n;
  endfunction

  function automatic logic [CH_WIDTH-1:0] dim_level(input logic [1:0] d);
    return {CH_WIDTH{1'b1}} >> d;
  endfunction

  function automatic logic [3*CH_WIDTH-1:0] decode(input logic [2:0] c,
                                                   input logic [CH_WIDTH-1:0] on);
    return {{CH_WIDTH{c[2]}} & on, {CH_WIDTH{c[1]}} & on, {CH_WIDTH{c[0]}} & on};
  endfunction

  // Next-state: colour, dwell counter, step pulse and the light word
  always_comb begin
    colour_nxt = colour;
    cnt_nxt    = '0;
    step_nxt   = 1'b0;
    light_nxt  = '0;
    on_level   = dim_level(dim);
    press      = button & ~btn_q;
    case (mode_t'(mode))
      MODE_WHITE: begin
        light_nxt = {3{on_level}};
      end
      MODE_MANUAL: begin
        light_nxt = decode(colour, on_level);
        if (press) begin
          colour_nxt = next_colour(colour, dir);
          step_nxt   = 1'b1;
        end
      end
      MODE_AUTO: begin
        light_nxt = decode(colour, on_level);
        cnt_nxt   = cnt;
        if (!button) begin
          if (cnt == CNT_LAST) begin
            colour_nxt = next_colour(colour, dir);
            step_nxt   = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        light_nxt = '0;
      end
    endcase
  end

  // Register stage: every output is driven straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      colour <= '0;
      cnt    <= '0;
      btn_q  <= 1'b0;
      step   <= 1'b0;
      light  <= '0;
    end else begin
      colour <= colour_nxt;
      cnt    <= cnt_nxt;
      btn_q  <= button;
      step   <= step_nxt;
      light  <= light_nxt;
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: directed test-plan scenarios followed
// by randomized traffic, checked against a behavioural colour-ring model.
module tb_light_sequencer;

  localparam int CH = 8;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic          button;
  logic          dir;
  logic [1:0]    dim;
  logic [3*CH-1:0] light;
  logic [2:0]    colour;
  logic          step;

  light_sequencer #(.CH_WIDTH(CH), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .button(button), .dir(dir),
    .dim(dim), .light(light), .colour(colour), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] light;
    logic [2:0]  colour;
    logic        step;
    int          edge_no;
  } exp_t;

  exp_t q[$];
  int   steps[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_edge   = 0;

  // model state: colour, cycles elapsed in current dwell, last button level
  int   m_col   = 0;
  int   m_el    = 0;
  logic m_btnq  = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic int ring_next(int c, logic rev);
    if (!rev) return (c % 6) + 1;
    return (c <= 1) ? 6 : c - 1;
  endfunction

  function automatic logic [23:0] model_light(logic [1:0] md, logic [1:0] dm, int c);
    int on;
    int bits;
    logic [23:0] r;
    on   = ((1 << CH) - 1) >> dm;
    bits = (md == 2'b00) ? 7 : (md == 2'b11) ? 0 : c;
    r    = '0;
    for (int ch = 0; ch < 3; ch++)
      if (bits[ch]) r = r | (24'(on) << (CH * ch));
    return r;
  endfunction

  task automatic cycle();
    exp_t e;
    logic press;
    press     = button && !m_btnq;
    e.edge_no = n_edge + 1;
    e.step    = 1'b0;
    if (rst) begin
      m_col  = 0;
      m_el   = 0;
      m_btnq = 1'b0;
      e.light = '0;
    end else begin
      e.light = model_light(mode, dim, m_col);
      if (mode == 2'b01) begin
        m_el = 0;
        if (press) begin
          m_col  = ring_next(m_col, dir);
          e.step = 1'b1;
        end
      end else if (mode == 2'b10) begin
        if (!button) begin
          m_el++;
          if (m_el == DW) begin
            m_col  = ring_next(m_col, dir);
            m_el   = 0;
            e.step = 1'b1;
          end
        end
      end else begin
        m_el = 0;
      end
      m_btnq = button;
    end
    e.colour = 3'(m_col);
    q.push_back(e);
    @(posedge clk);
    n_edge++;
    #1;
  endtask

  function automatic int first_step();
    return (steps.size() > 0) ? steps[0] : -1;
  endfunction

  // Monitor: the DUT presents a new word every clock
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_light", 64'(light), 64'(e.light));
        chk("sb_colour", 64'(colour), 64'(e.colour));
        chk("sb_step", 64'(step), 64'(e.step));
        if (step === 1'b1) steps.push_back(e.edge_no);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [23:0] man_tbl [7];
  int start;

  initial begin
    man_tbl = '{24'h0000FF, 24'h00FF00, 24'h00FFFF, 24'hFF0000,
                24'hFF00FF, 24'hFFFF00, 24'h0000FF};
    rst = 1'b1; mode = 2'b00; button = 1'b0; dir = 1'b0; dim = 2'd0;

    // reset and white
    repeat (2) cycle();
    chk("reset_light", 64'(light), 64'h0);
    chk("reset_colour", 64'(colour), 64'h0);
    chk("reset_step", 64'(step), 64'h0);
    rst = 1'b0;
    cycle();
    chk("white_full", 64'(light), 64'hFFFFFF);
    dim = 2'd2;
    cycle();
    chk("white_dim2", 64'(light), 64'h3F3F3F);

    // manual forward with wrap
    dim = 2'd0; mode = 2'b01; dir = 1'b0;
    steps.delete();
    for (int k = 0; k < 7; k++) begin
      button = 1'b1; cycle();
      button = 1'b0; cycle();
      chk($sformatf("manual_light_%0d", k), 64'(light), 64'(man_tbl[k]));
      cycle();
    end
    chk("manual_step_count", 64'(steps.size()), 64'd7);

    // held button gives a single step
    steps.delete();
    button = 1'b1;
    repeat (10) cycle();
    button = 1'b0;
    repeat (2) cycle();
    chk("held_step_count", 64'(steps.size()), 64'd1);
    chk("held_colour", 64'(colour), 64'd2);

    // auto reverse with a 3-cycle pause
    rst = 1'b1; cycle(); rst = 1'b0;
    mode = 2'b10; dir = 1'b1; button = 1'b0;
    steps.delete();
    start = n_edge;
    repeat (12) cycle();
    chk("auto_rev_colour4", 64'(colour), 64'd4);
    cycle();
    button = 1'b1; repeat (3) cycle();
    button = 1'b0; repeat (3) cycle();
    chk("auto_rev_colour3", 64'(colour), 64'd3);
    cycle();
    chk("auto_step_count", 64'(steps.size()), 64'd4);
    if (steps.size() == 4) begin
      chk("auto_first_step", 64'(steps[0] - start), 64'd4);
      chk("auto_interval_1", 64'(steps[1] - steps[0]), 64'd4);
      chk("auto_interval_2", 64'(steps[2] - steps[1]), 64'd4);
      chk("auto_pause_interval", 64'(steps[3] - steps[2]), 64'd7);
    end

    // mode change mid-dwell (cnt = 2), then back to auto
    cycle();
    mode = 2'b11;
    cycle();
    chk("off_light", 64'(light), 64'h0);
    chk("off_colour_held", 64'(colour), 64'd3);
    mode = 2'b10;
    steps.delete();
    start = n_edge;
    repeat (6) cycle();
    chk("reentry_first_step", 64'(first_step() - start), 64'd4);

    // reset mid-operation at colour 3
    dir = 1'b0;
    repeat (2) cycle();
    chk("pre_reset_colour", 64'(colour), 64'd3);
    rst = 1'b1;
    cycle();
    chk("midrst_colour", 64'(colour), 64'h0);
    chk("midrst_light", 64'(light), 64'h0);
    chk("midrst_step", 64'(step), 64'h0);
    rst = 1'b0;
    steps.delete();
    start = n_edge;
    repeat (5) cycle();
    chk("restart_first_step", 64'(first_step() - start), 64'd4);
    chk("restart_colour", 64'(colour), 64'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      button = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) dim = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    #10;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Parametrised RGB light sequencer: the next generation of the Ex7 lights selector. It generalises the fixed 24-bit white/colour selector to a configurable channel width and adds four modes: white, manual step, timed auto-cycle and off. It also adds direction control, brightness dimming and edge-detected button stepping. It sits between the user-input debounce logic and the LED driver, and supplies one registered RGB word per clock.

## Interface
- CH_WIDTH, 8, bits per colour channel; light is 3*CH_WIDTH wide, ordered {R,G,B}
- DWELL, 4, clock cycles each colour is held in auto mode; legal range is 1 or more
- clk  input  1  rising-edge clock; the block uses one clock only
- rst  input  1  synchronous, active-high reset
- mode  input  2  00 white, 01 manual step, 10 auto-cycle, 11 off
- button  input  1  manual mode: a rising edge advances one colour; auto mode: level high pauses the cycle
- dir  input  1  0 forward (1→6), 1 reverse (6→1)
- dim  input  2  brightness: channel-on value = all-ones >> dim
- light  output  3*CH_WIDTH  registered RGB word
- colour  output  3  current colour index {R,G,B}
- step  output  1  one-cycle pulse on the cycle that colour changes

## Operation
- Colour codes: 1 blue, 2 green, 3 cyan, 4 red, 5 magenta, 6 yellow. Bit 2 is R, bit 1 is G, bit 0 is B. Codes 0 and 7 never result from stepping.
- Channel value: ON = {CH_WIDTH{1'b1}} >> dim; OFF = 0.
- Next-colour rule, forward: 1→2→…→6→1.
- Next-colour rule, reverse: 6→5→…→1→6.
- Stepping from 0 (reset state) gives 1 when forward and 6 when reverse.
- Edge detect: btn_q registers button every cycle. press = button & ~btn_q.
- White (00): every channel = ON. colour is held. The dwell counter is cleared. step = 0.
- Manual (01): on a cycle with press = 1, colour takes the next-colour value and step = 1.
  - Holding button high gives exactly one step.
  - The dwell counter is cleared.
  - light shows each channel as ON or OFF per its colour bit.
  - With colour = 0, light = 0.
- Auto (10): the dwell counter cnt runs from 0 to DWELL-1.
  - When cnt = DWELL-1 and button = 0: colour steps, step = 1, cnt → 0.
  - Otherwise, when button = 0: cnt increments.
  - When button = 1: cnt and colour hold (pause). press has no effect.
  - light is decoded from colour as in manual mode.
- Off (11): light = 0. colour is held. cnt is cleared.
- Mode change: cnt is cleared on every cycle that mode ≠ 10, so auto mode always starts a full dwell from 0. colour carries over between modes.
- dir and dim are sampled every cycle. Changing dir mid-dwell affects only the next step.
- DWELL = 1: auto mode steps every cycle while button = 0.
- Counter width: $clog2(DWELL), minimum 1 bit. It must never exceed DWELL-1.

## Timing
- Reset (rst = 1 at an edge) sets colour = 0, light = 0, step = 0, cnt = 0, btn_q = 0. Reset overrides every other input, including mid-dwell and mid-press.
- After rst falls, a button already held high counts as a press on the first non-reset edge, because btn_q = 0.
- colour and step update at the edge where the step condition is sampled true.
- light is registered from mode, dim and colour as they stand before that edge. Consequences:
  - light reflects a new colour one clock after the colour and step update.
  - light reflects a mode or dim change at the next edge.
- Manual latency: button is first sampled high at edge E. colour and step update at E. light updates at E+1.
- Auto period: exactly DWELL cycles between step pulses while unpaused. A pause of P cycles stretches that interval to DWELL+P.

## Test plan
- Reset and white: rst = 1 for 2 cycles → light = 0, colour = 0. Then rst = 0, mode = 00, dim = 0 → light = FFFFFF after one edge. dim = 2 → light = 3F3F3F.
- Manual forward with wrap: mode = 01, dir = 0, seven single-cycle presses spaced 3 cycles apart → light sequence 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, 0000FF. Each press gives exactly one step pulse.
- Held button: mode = 01, button held high for 10 cycles → exactly one step; colour changes once only.
- Auto with reverse and pause: mode = 10, DWELL = 4, dir = 1, from colour 0 → colour 6, 5, 4 at 4-cycle intervals. Button high for 3 cycles mid-dwell → that interval is 7 cycles.
- Mode changes: in auto at cnt = 2, switch to 11 → light = 0 next edge, colour held. Return to 10 → first step 4 cycles later.
- Reset mid-operation: rst pulsed during auto at colour 3 → colour = 0, light = 0, step = 0 on the following edge. Auto then restarts at colour 1 (forward) after DWELL cycles.
